// File: rtl/dec49_case.sv
// rtl/dec49_case.sv - registered BCD to seven-segment decoder with lamp test, blanking and ripple blanking
//
// Purpose: decodes a BCD digit onto seven segment drives, one cycle after the
// inputs are presented. Every output comes straight from a flop.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset, outputs go dark at once
//   q          in   4  BCD digit, valid codes 0-9
//   lamp_test  in   1  light every segment (highest priority)
//   blank      in   1  darken every segment
//   rbi        in   1  ripple-blank-in, suppresses a zero digit
//   d          out  7  segments, d[6]=a ... d[0]=g
//   rbo        out  1  this digit was zero-suppressed
//   err        out  1  q holds an invalid code 10-15
//
// COMMON_ANODE=1 inverts every d bit so a lit segment is driven low.

module dec49_case #(
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q,
  input  logic       lamp_test,
  input  logic       blank,
  input  logic       rbi,
  output logic [6:0] d,
  output logic       rbo,
  output logic       err
);

  // XOR mask applied to the active-high segment pattern.
  localparam logic [6:0] POLARITY = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

  logic [6:0] seg_d;
  logic [6:0] d_d;
  logic       rbo_d;
  logic       err_d;

  logic [6:0] d_q;
  logic       rbo_q;
  logic       err_q;

  // Active-high segment pattern; dark is the all-zero default.
  always_comb begin
    seg_d = 7'h00;
    rbo_d = 1'b0;
    err_d = 1'b0;
    if (lamp_test) begin
      seg_d = 7'h7F;
    end else if (blank) begin
      seg_d = 7'h00;
    end else if (rbi && (q == 4'd0)) begin
      rbo_d = 1'b1;
    end else begin
      case (q)
        4'd0:    seg_d = 7'h7E;
        4'd1:    seg_d = 7'h30;
        4'd2:    seg_d = 7'h6D;
        4'd3:    seg_d = 7'h79;
        4'd4:    seg_d = 7'h33;
        4'd5:    seg_d = 7'h5B;
        4'd6:    seg_d = 7'h5F;
        4'd7:    seg_d = 7'h70;
        4'd8:    seg_d = 7'h7F;
        4'd9:    seg_d = 7'h7B;
        default: err_d = 1'b1;
      endcase
    end
    d_d = seg_d ^ POLARITY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q   <= POLARITY;
      rbo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      rbo_q <= rbo_d;
      err_q <= err_d;
    end
  end

  assign d   = d_q;
  assign rbo = rbo_q;
  assign err = err_q;

endmodule

// File: tb/tb_dec49_case.sv
// tb/tb_dec49_case.sv - self-checking bench for dec49_case, common cathode and common anode instances

module tb_dec49_case;

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic       lamp_test;
  logic       blank;
  logic       rbi;
  logic [6:0] d0, d1;
  logic       rbo0, rbo1, err0, err1;

  int checks;
  int errors;

  // Segment patterns for digits 0-9, active-high.
  logic [6:0] seg_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  dec49_case #(.COMMON_ANODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .q(q), .lamp_test(lamp_test), .blank(blank), .rbi(rbi),
    .d(d0), .rbo(rbo0), .err(err0)
  );

  dec49_case #(.COMMON_ANODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .q(q), .lamp_test(lamp_test), .blank(blank), .rbi(rbi),
    .d(d1), .rbo(rbo1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {d[6:0], rbo, err} for a common-cathode display.
  function automatic logic [8:0] model(input logic [3:0] qq, input logic lt,
                                       input logic bl, input logic rb);
    if (lt)                    return {7'h7F, 1'b0, 1'b0};
    else if (bl)               return {7'h00, 1'b0, 1'b0};
    else if (rb && qq == 4'd0) return {7'h00, 1'b1, 1'b0};
    else if (qq > 4'd9)        return {7'h00, 1'b0, 1'b1};
    else                       return {seg_tbl[qq], 1'b0, 1'b0};
  endfunction

  // Both instances expected together: common anode is the bitwise inverse on d only.
  function automatic logic [17:0] both(input logic [8:0] m);
    return {m[8:2], m[1:0], ~m[8:2], m[1:0]};
  endfunction

  function automatic logic [17:0] observed();
    return {d0, rbo0, err0, d1, rbo1, err1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    #2;
    obs = observed();
    checks++;
    if (obs !== {7'h00, 2'b00, 7'h7F, 2'b00}) begin
      errors++;
      $display("FAIL reset_immediate: got %h expected %h", obs, {7'h00, 2'b00, 7'h7F, 2'b00});
    end
    q = 4'd8;
    step();
    step();
    obs = observed();
    checks++;
    if (obs !== {7'h00, 2'b00, 7'h7F, 2'b00}) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, {7'h00, 2'b00, 7'h7F, 2'b00});
    end
    rst = 1'b0;
    step();
    obs = observed();
    checks++;
    if (obs !== both(model(4'd8, 1'b0, 1'b0, 1'b0)) || d0 !== 7'h7F) begin
      errors++;
      $display("FAIL reset_first_edge: got %h expected %h", obs, both(model(4'd8, 1'b0, 1'b0, 1'b0)));
    end
  endtask

  task automatic test_sweep();
    logic [17:0] obs;
    for (int i = 0; i < 10; i++) begin
      q = 4'(i);
      step();
      obs = observed();
      checks++;
      if (obs !== both({seg_tbl[i], 2'b00})) begin
        errors++;
        $display("FAIL sweep_q%0d: got %h expected %h", i, obs, both({seg_tbl[i], 2'b00}));
      end
    end
    q = 4'd2;
    step();
    checks++;
    if (d0 !== 7'h6D) begin
      errors++;
      $display("FAIL sweep_q2_const: got %h expected 6d", d0);
    end
  endtask

  task automatic test_invalid();
    logic [17:0] obs;
    for (int i = 10; i < 16; i++) begin
      q = 4'(i);
      step();
      obs = observed();
      checks++;
      if (obs !== {7'h00, 2'b01, 7'h7F, 2'b01}) begin
        errors++;
        $display("FAIL invalid_q%0d: got %h expected %h", i, obs, {7'h00, 2'b01, 7'h7F, 2'b01});
      end
    end
    q = 4'd3;
    step();
    checks++;
    if ({d0, err0} !== {7'h79, 1'b0}) begin
      errors++;
      $display("FAIL invalid_recover: got d=%h err=%b expected d=79 err=0", d0, err0);
    end
  endtask

  task automatic test_priority();
    q = 4'd5; lamp_test = 1'b1; blank = 1'b1;
    step();
    checks++;
    if ({d0, rbo0, err0} !== {7'h7F, 2'b00}) begin
      errors++;
      $display("FAIL prio_lamp: got %h expected 7f", d0);
    end
    lamp_test = 1'b0;
    step();
    checks++;
    if ({d0, rbo0, err0} !== {7'h00, 2'b00}) begin
      errors++;
      $display("FAIL prio_blank: got %h expected 00", d0);
    end
    blank = 1'b0;
    step();
    checks++;
    if ({d0, rbo0, err0} !== {7'h5B, 2'b00}) begin
      errors++;
      $display("FAIL prio_normal: got %h expected 5b", d0);
    end
    q = 4'd12; lamp_test = 1'b1;
    step();
    checks++;
    if ({d0, rbo0, err0} !== {7'h7F, 2'b00}) begin
      errors++;
      $display("FAIL prio_lamp_invalid: got %h expected %h", {d0, rbo0, err0}, {7'h7F, 2'b00});
    end
    lamp_test = 1'b0; rbi = 1'b1; q = 4'd0; blank = 1'b1;
    step();
    checks++;
    if ({d0, rbo0, err0} !== {7'h00, 2'b00}) begin
      errors++;
      $display("FAIL prio_blank_over_rbi: got %h expected %h", {d0, rbo0, err0}, {7'h00, 2'b00});
    end
    blank = 1'b0; rbi = 1'b0;
  endtask

  task automatic test_rbi();
    rbi = 1'b1; q = 4'd0;
    step();
    checks++;
    if ({d0, rbo0, err0, d1, rbo1} !== {7'h00, 2'b10, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL rbi_zero: got d=%h rbo=%b expected d=00 rbo=1", d0, rbo0);
    end
    q = 4'd1;
    step();
    checks++;
    if ({d0, rbo0} !== {7'h30, 1'b0}) begin
      errors++;
      $display("FAIL rbi_nonzero: got d=%h rbo=%b expected d=30 rbo=0", d0, rbo0);
    end
    rbi = 1'b0; q = 4'd0;
    step();
    checks++;
    if ({d0, rbo0} !== {7'h7E, 1'b0}) begin
      errors++;
      $display("FAIL rbi_off_zero: got d=%h rbo=%b expected d=7e rbo=0", d0, rbo0);
    end
  endtask

  task automatic test_hold();
    q = 4'd2;
    step();
    q = 4'd7;
    #4;
    checks++;
    if (d0 !== 7'h6D) begin
      errors++;
      $display("FAIL hold_between_edges: got %h expected 6d", d0);
    end
    step();
    checks++;
    if (d0 !== 7'h70) begin
      errors++;
      $display("FAIL hold_next_edge: got %h expected 70", d0);
    end
  endtask

  task automatic test_async_reset();
    q = 4'd8;
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({d0, rbo0, err0, d1} !== {7'h00, 2'b00, 7'h7F}) begin
      errors++;
      $display("FAIL async_reset: got d0=%h d1=%h expected d0=00 d1=7f", d0, d1);
    end
    q = 4'd4;
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (observed() !== both({7'h33, 2'b00})) begin
      errors++;
      $display("FAIL async_reset_release: got %h expected %h", observed(), both({7'h33, 2'b00}));
    end
  endtask

  task automatic test_common_anode();
    q = 4'd1;
    step();
    checks++;
    if ({d1, rbo1, err1} !== {7'h4F, 2'b00}) begin
      errors++;
      $display("FAIL ca_digit1: got %h expected 4f", d1);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (d1 !== 7'h7F) begin
      errors++;
      $display("FAIL ca_reset: got %h expected 7f", d1);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [17:0] exp;
    logic [17:0] obs;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      q         = 4'($urandom_range(0, 15));
      lamp_test = ($urandom % 8) == 0;
      blank     = ($urandom % 6) == 0;
      rbi       = ($urandom % 2) == 0;
      exp = both(model(q, lamp_test, blank, rbi));
      step();
      obs = observed();
      checks++;
      if (obs !== exp) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: got %h expected %h", i, obs, exp);
      end
    end
    lamp_test = 1'b0; blank = 1'b0; rbi = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    q = 4'd0;
    lamp_test = 1'b0;
    blank = 1'b0;
    rbi = 1'b0;
    test_reset();
    test_sweep();
    test_invalid();
    test_priority();
    test_rbi();
    test_hold();
    test_async_reset();
    test_common_anode();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec49_case.md
DEC49_CASE -- requirements
Module: dec49_case

Interface
REQ-001 Parameter COMMON_ANODE, default 0: 0 = segment lit by 1 on d; 1 = all d bits inverted (lit by 0).
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-003 Port declaration order SHALL follow this list.
REQ-004 clk  input  1  rising-edge clock; all outputs registered on it.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 q  input  4  BCD digit to display; valid codes 0-9.
REQ-007 lamp_test  input  1  forces all seven segments lit.
REQ-008 blank  input  1  forces all segments dark.
REQ-009 rbi  input  1  ripple-blank-in; blanks a zero digit (leading-zero suppression).
REQ-010 d  output  7  segment drive, d[6]=a, d[5]=b, d[4]=c, d[3]=d, d[2]=e, d[1]=f, d[0]=g.
REQ-011 rbo  output  1  ripple-blank-out; 1 when this digit was zero-suppressed.
REQ-012 err  output  1  1 when q holds an invalid code 10-15.

Function
REQ-013 Each rising clk edge SHALL register d, rbo and err from the current inputs; latency is exactly 1 cycle, no combinational input-to-output path.
REQ-014 With COMMON_ANODE=0, the normal decode on d[6:0] SHALL be:
- 0 -> 0x7E
- 1 -> 0x30
- 2 -> 0x6D
- 3 -> 0x79
- 4 -> 0x33
- 5 -> 0x5B
- 6 -> 0x5F
- 7 -> 0x70
- 8 -> 0x7F
- 9 -> 0x7B
REQ-015 q = 10-15 SHALL produce d = all dark and err=1; for q = 0-9, err=0.
REQ-016 Priority, highest first: lamp_test, then blank, then (rbi and q==0), then normal decode.
REQ-017 lamp_test=1 -> all segments lit (d=0x7F at COMMON_ANODE=0), err=0, rbo=0, regardless of q.
REQ-018 blank=1 with lamp_test=0 -> all segments dark, err=0, rbo=0.
REQ-019 rbi=1 and q==0, with lamp_test=0 and blank=0 -> all segments dark, rbo=1, err=0.
REQ-020 rbo SHALL be 0 in every case other than REQ-019.
REQ-021 With COMMON_ANODE=1, every d value SHALL be the bitwise inverse of the COMMON_ANODE=0 value; rbo and err are unaffected.
REQ-022 Input changes between clock edges SHALL not affect outputs until the next rising edge.

Reset
REQ-023 rst=1 SHALL immediately, without a clock edge, force:
- d = all dark (0x00 at COMMON_ANODE=0, 0x7F at COMMON_ANODE=1)
- rbo = 0
- err = 0
REQ-024 Outputs SHALL hold their reset values while rst=1.
REQ-025 After rst deasserts, the first rising edge SHALL load the decode of the current inputs.
REQ-026 Asserting rst mid-sequence SHALL override any displayed digit at once.

Verification
REQ-027 Sweep q = 0..9, one value per cycle, control inputs low -> d follows REQ-014 one cycle later (e.g. q=2 -> 0x6D, q=9 -> 0x7B); err=0.
REQ-028 q = 10..15 -> d=0x00 and err=1 one cycle later; then q=3 -> d=0x79 and err=0.
REQ-029 q=5 with lamp_test=1 and blank=1 -> d=0x7F; drop lamp_test -> d=0x00; drop blank -> d=0x5B.
REQ-030 rbi=1 with q=0 -> d=0x00 and rbo=1; then q=1 -> d=0x30 and rbo=0; rbi=0 with q=0 -> d=0x7E.
REQ-031 Assert rst asynchronously while d=0x7F -> d=0x00 before the next edge; deassert -> next edge shows the decode of the current q.
REQ-032 COMMON_ANODE=1 instance, q=1 -> d=0x4F; after reset -> d=0x7F.
